// File: rtl/bin_mgr_pkg.sv
// rtl/bin_mgr_pkg.sv - shared vars-states widths, engine ids and arbiter state encoding
//
// Purpose : constants shared by the bin-manager engines and the RAM arbiters.
// Contents: vars-states word/address widths, engine index constants,
//           arbiter FSM state type.
package bin_mgr_pkg;

  localparam int WIDTH_VAR_STATES       = 30;
  localparam int ADDR_WIDTH_VARS_STATES = 9;

  // Engine slots on the arbiter request/grant vectors.
  localparam int ENG_LOAD   = 0;
  localparam int ENG_UPDATE = 1;
  localparam int ENG_BKT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose : choose the first set request bit strictly after the last
//           winner, wrapping around. Shared by the RAM arbiters.
// Ports   : i_req    - request vector (N bits)
//           i_last   - index of the previous winner
//           o_winner - index of the chosen requester (0 when none)
//           o_any    - at least one request bit is set
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  int w_dist;
  int w_best;

  // Each candidate is ranked by its distance after i_last: last+1 has
  // distance 0, last itself has distance N-1. Smallest distance wins.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_dist   = 0;
    w_best   = N;
    for (int k = 0; k < N; k++) begin
      if (i_req[k]) begin
        w_dist = (k + N - 1 - int'(i_last)) % N;
        if (w_dist < w_best) begin
          w_best   = w_dist;
          o_winner = IW'(k);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vs_ram_arbiter.sv
// rtl/vs_ram_arbiter.sv - round-robin owner arbiter for the vars-states BRAM
//
// Purpose : shares the vars-states BRAM read/write ports among NUM_REQ
//           bin-manager engines. A grant is held for a whole operation;
//           the owner's buses are muxed onto the RAM, read data is broadcast.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           req_i / gnt_o       - per-engine request / registered one-hot grant
//           owner_o, busy_o     - current owner index, grant active
//           raddr_i, we_i, waddr_i, wdata_i - packed per-engine RAM buses
//           rdata_o             - RAM read data to all engines
//           ram_raddr_o, ram_rdata_i, ram_we_o, ram_waddr_o, ram_wdata_o - BRAM side
//           err_o               - sticky: a non-owner tried to write
module vs_ram_arbiter #(
  parameter int NUM_REQ                = 3,
  parameter int OWNER_W                = 2,
  parameter int WIDTH_VAR_STATES       = bin_mgr_pkg::WIDTH_VAR_STATES,
  parameter int ADDR_WIDTH_VARS_STATES = bin_mgr_pkg::ADDR_WIDTH_VARS_STATES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [OWNER_W-1:0]                    owner_o,
  output logic                                  busy_o,
  input  logic [NUM_REQ*ADDR_WIDTH_VARS_STATES-1:0] raddr_i,
  input  logic [NUM_REQ-1:0]                    we_i,
  input  logic [NUM_REQ*ADDR_WIDTH_VARS_STATES-1:0] waddr_i,
  input  logic [NUM_REQ*WIDTH_VAR_STATES-1:0]   wdata_i,
  output logic [WIDTH_VAR_STATES-1:0]           rdata_o,
  output logic [ADDR_WIDTH_VARS_STATES-1:0]     ram_raddr_o,
  input  logic [WIDTH_VAR_STATES-1:0]           ram_rdata_i,
  output logic                                  ram_we_o,
  output logic [ADDR_WIDTH_VARS_STATES-1:0]     ram_waddr_o,
  output logic [WIDTH_VAR_STATES-1:0]           ram_wdata_o,
  output logic                                  err_o
);

  import bin_mgr_pkg::*;

  localparam int AW = ADDR_WIDTH_VARS_STATES;
  localparam int DW = WIDTH_VAR_STATES;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] w_owner_nxt;
  logic [OWNER_W-1:0] r_last;
  logic [OWNER_W-1:0] w_last_nxt;
  logic               r_err;

  logic [OWNER_W-1:0] w_winner;
  logic               w_any_req;
  logic               w_owner_req;
  logic               w_rogue_we;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OWNER_W)
  ) u_rr_pick (
    .i_req    (req_i),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any_req)
  );

  // r_gnt is one-hot on the owner during GRANT, so masking req_i with it
  // gives the owner's request without a variable bit-select.
  assign w_owner_req = |(req_i & r_gnt);

  // Any write enable from an engine not currently holding a grant.
  assign w_rogue_we  = |(we_i & ~r_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= OWNER_W'(NUM_REQ - 1);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_err   <= r_err | w_rogue_we;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt   = NUM_REQ'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // No preemption: only the owner dropping its request ends the grant.
        if (!w_owner_req) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM-side mux: only the owner's buses reach the BRAM, and only in GRANT.
  always_comb begin
    ram_raddr_o = '0;
    ram_we_o    = 1'b0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    if (r_state == ST_GRANT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (r_owner == OWNER_W'(k)) begin
          ram_raddr_o = raddr_i[k*AW +: AW];
          ram_we_o    = we_i[k];
          ram_waddr_o = waddr_i[k*AW +: AW];
          ram_wdata_o = wdata_i[k*DW +: DW];
        end
      end
    end
  end

  assign gnt_o   = r_gnt;
  assign owner_o = r_owner;
  assign busy_o  = (r_state == ST_GRANT);
  assign err_o   = r_err;
  assign rdata_o = ram_rdata_i;

endmodule

// File: doc/vs_ram_arbiter.md
Name: vs_ram_arbiter

Overview:
- Shares the single vars-states BRAM (read port plus write port) among NUM_REQ bin-manager engines, e.g. load-bin, update-across-bin and backtrack-across-bin.
- Grants are round-robin, and each grant is held for a whole operation. The owner's address, write and data buses are muxed onto the RAM, and read data is broadcast to all engines.
- Sits between the bin-manager engines and the vars-states BRAM. It replaces the ad-hoc apply_* mux-select signals.

Parameters:
- NUM_REQ, 3, number of requesting engines (2..4).
- OWNER_W, 2, width of the owner index; must satisfy 2**OWNER_W >= NUM_REQ.
- WIDTH_VAR_STATES, 30, width of one vars-states word.
- ADDR_WIDTH_VARS_STATES, 9, vars-states RAM address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  NUM_REQ  per-engine request, held high for the whole operation.
- gnt_o  out  NUM_REQ  one-hot grant, registered.
- owner_o  out  OWNER_W  index of the current grant holder; valid while busy_o=1.
- busy_o  out  1  high while the FSM is in GRANT.
- raddr_i  in  NUM_REQ*ADDR_WIDTH_VARS_STATES  per-engine read address; engine k occupies slice k.
- we_i  in  NUM_REQ  per-engine write enable.
- waddr_i  in  NUM_REQ*ADDR_WIDTH_VARS_STATES  per-engine write address.
- wdata_i  in  NUM_REQ*WIDTH_VAR_STATES  per-engine write data.
- rdata_o  out  WIDTH_VAR_STATES  RAM read data, broadcast to all engines.
- ram_raddr_o  out  ADDR_WIDTH_VARS_STATES  RAM read address.
- ram_rdata_i  in  WIDTH_VAR_STATES  RAM read data.
- ram_we_o  out  1  RAM write enable.
- ram_waddr_o  out  ADDR_WIDTH_VARS_STATES  RAM write address.
- ram_wdata_o  out  WIDTH_VAR_STATES  RAM write data.
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, gnt_o=0, owner_o=0, busy_o=0, err_o=0.
  - Round-robin pointer last=NUM_REQ-1, so engine 0 wins first.
  - ram_we_o=0 and ram_*addr_o/ram_wdata_o=0 from that edge on.
  - A reset during GRANT aborts the grant at the same edge; the engine must restart.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req_i bit is set at the edge, pick the first set bit scanning from last+1 upward with wrap.
  - At that edge: gnt_o<=onehot(winner), owner_o<=winner, last<=winner, go to GRANT.
  - Grant latency is 1 cycle after req_i is sampled high.
- GRANT:
  - Hold the grant while req_i[owner] is high.
  - When req_i[owner] is sampled low: gnt_o<=0, go to RELEASE.
  - Requests from other engines are ignored in GRANT; there is no preemption.
- RELEASE:
  - One bubble cycle with ram_we_o forced 0, then IDLE.
  - The minimum gap between two grants is 2 cycles with gnt_o=0.
- Muxing (combinational from owner_o and state):
  - In GRANT: ram_raddr_o=raddr_i[owner], ram_we_o=we_i[owner], ram_waddr_o=waddr_i[owner], ram_wdata_o=wdata_i[owner].
  - Otherwise all four are driven 0.
- Read data: rdata_o=ram_rdata_i, passed straight through. The 1-cycle BRAM read latency is the engine's responsibility.
- Simultaneous requests: round-robin only; no fixed priority except immediately after reset.
- Owner drops req and re-asserts it in the same cycle another engine requests: the other engine wins, because last = old owner.
- err_o:
  - Set when we_i[k]=1 for any k with gnt_o[k]=0 at an edge; that write is dropped.
  - Cleared only by rst.
- Widths: slice k of each packed bus is [k*W +: W]. Bits of req_i beyond NUM_REQ do not exist, so no tie-off is needed.

Decomposition:
- Shared package bin_mgr_pkg holds:
  - Vars-states widths WIDTH_VAR_STATES and ADDR_WIDTH_VARS_STATES.
  - Engine index constants ENG_LOAD=0, ENG_UPDATE=1, ENG_BKT=2.
  - The FSM state encoding.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector and last pointer.
  - Outputs: winner index and any-request flag.
  - Reusable for the lvls-states arbiter.

Test Plan:
- Reset then req_i=3'b001 → gnt_o=3'b001 one cycle later, busy_o=1, owner_o=0. Engine 0 writes addr 5, data 30'h123 → ram_we_o=1, ram_waddr_o=5, ram_wdata_o=30'h123 in the same cycle.
- req_i=3'b111 from reset, each engine holding req for 4 cycles → grants in order 0,1,2. Each grant lasts 4 cycles, separated by exactly 2 cycles of gnt_o=0.
- Owner 1 holding grant, engine 2 raises req → no change until engine 1 drops req. Then RELEASE (ram_we_o=0), then gnt_o=3'b100.
- Engine 2 asserts we_i while engine 0 owns the grant → ram_we_o follows engine 0 only, err_o=1 next edge and stays 1 until rst.
- rst=1 mid-GRANT while owner writes → after that edge gnt_o=0, ram_we_o=0, busy_o=0. Next request from engine 1 with req_i=3'b011 → engine 0 wins, because the pointer was reset.
- Owner 0 drops req while engine 1 requests and engine 0 immediately re-requests → engine 1 is granted next.
